input_irq_controller: RTL and testbench

//  Parametrised successor of the switch controller. Synchronises and debounces WIDTH raw inputs
//  (switches/buttons), latches changed bits into a sticky per-bit pending register, and raises an

---
 rtl/input_irq_controller.sv | 150 +++++++++++++++
 tb/tb_input_irq_controller.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/input_irq_controller.sv
// Input IRQ controller: synchronised, debounced inputs with sticky pending bits and a req/fin
// interrupt handshake. Define IRQ_EDGE_SEL_EN to enable the per-channel EDGE select register (WIDTH<=16).
module input_irq_controller #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic [31:0] IRQ_ID          = 32'h20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_raw,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             we,
  output logic [31:0]      rdata,
  output logic [31:0]      int_req_o,
  input  logic [31:0]      int_fin_i
);

  localparam int unsigned   CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sync_q1, sync_q2;
  logic [WIDTH-1:0] stable, pending, mask;
  logic [WIDTH-1:0] accept, pend_set, w1c;
  logic [CW-1:0]    cnt [WIDTH];
  logic [1:0]       reg_sel;
  logic             irq_cond;
  logic             unused_bits;

  assign reg_sel     = addr[3:2];
  assign unused_bits = ^{addr[31:4], addr[1:0], wdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= in_raw;
      sync_q2 <= sync_q1;
    end
  end

  // A bit is accepted on the edge where it has differed for DEBOUNCE_CYCLES samples in a row.
  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      accept[i] = (sync_q2[i] != stable[i]) && (cnt[i] == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
      for (int unsigned i = 0; i < WIDTH; i++)
        cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync_q2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync_q2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

`ifdef IRQ_EDGE_SEL_EN
  logic [2*WIDTH-1:0] edge_sel;

  always_ff @(posedge clk) begin
    if (rst)
      edge_sel <= '0;
    else if (we && reg_sel == 2'd3)
      edge_sel <= wdata[2*WIDTH-1:0];
  end

  // The accepted level is the new level: 1 means a rising transition.
  always_comb begin
    pend_set = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      case (edge_sel[2*i +: 2])
        2'b00:   pend_set[i] = accept[i];
        2'b01:   pend_set[i] = accept[i] & sync_q2[i];
        2'b10:   pend_set[i] = accept[i] & ~sync_q2[i];
        default: pend_set[i] = 1'b0;
      endcase
    end
  end
`else
  assign pend_set = accept;
`endif

  assign w1c = (we && reg_sel == 2'd1) ? wdata[WIDTH-1:0] : '0;

  // Set is OR-ed after the clear so a same-cycle set wins over W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      mask    <= '1;
    end else begin
      pending <= (pending & ~w1c) | pend_set;
      if (we && reg_sel == 2'd2)
        mask <= wdata[WIDTH-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0:    rdata[WIDTH-1:0] = stable;
      2'd1:    rdata[WIDTH-1:0] = pending;
      2'd2:    rdata[WIDTH-1:0] = mask;
      default: begin
`ifdef IRQ_EDGE_SEL_EN
        rdata[2*WIDTH-1:0] = edge_sel;
`endif
      end
    endcase
  end

  assign irq_cond = |(pending & mask);

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    int_req_o  = '0;
    case (state)
      IDLE: if (irq_cond) state_next = REQ;
      REQ: begin
        int_req_o = IRQ_ID;
        if (int_fin_i == IRQ_ID)
          state_next = ACK;
      end
      ACK:     state_next = irq_cond ? REQ : IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_input_irq_controller.sv
// Directed bench for input_irq_controller (WIDTH=16, DEBOUNCE_CYCLES=4, IRQ_ID=0x20).
module tb_input_irq_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_raw;
  logic [31:0] addr, wdata, rdata, int_req_o, int_fin_i;
  logic        we;

  int n_cmp = 0;
  int n_bad = 0;

  input_irq_controller #(
    .WIDTH(16),
    .DEBOUNCE_CYCLES(4),
    .IRQ_ID(32'h20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_raw(in_raw),
    .addr(addr),
    .wdata(wdata),
    .we(we),
    .rdata(rdata),
    .int_req_o(int_req_o),
    .int_fin_i(int_fin_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] raw;
    logic [31:0] fin;
    logic        wr;
    logic [1:0]  wreg;
    logic [31:0] wdat;
    int          steps;
    logic [1:0]  rreg;
    logic [31:0] exp_rd;
    logic [31:0] exp_req;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic [15:0] raw, logic [31:0] fin, logic wr, logic [1:0] wreg,
                              logic [31:0] wdat, int steps, logic [1:0] rreg,
                              logic [31:0] exp_rd, logic [31:0] exp_req);
    vec_t v;
    v.raw = raw; v.fin = fin; v.wr = wr; v.wreg = wreg; v.wdat = wdat; v.steps = steps;
    v.rreg = rreg; v.exp_rd = exp_rd; v.exp_req = exp_req;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] r, input string name, input logic [31:0] exp);
    addr = {28'h0, r, 2'b00};
    #1;
    check(name, rdata, exp);
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    addr = {28'h0, r, 2'b00}; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_raw = '0; addr = '0; wdata = '0; we = 1'b0; int_fin_i = '0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;

    //        raw      fin    wr reg wdata        st rreg exp_rd       exp_req
    vt.push_back(mk(16'h0000, 32'h0,  0, 0, 32'h0,        1, 0, 32'h0,        32'h0));  // reset
    vt.push_back(mk(16'h0000, 32'h0,  0, 0, 32'h0,        1, 1, 32'h0,        32'h0));
    vt.push_back(mk(16'h0000, 32'h0,  0, 0, 32'h0,        1, 2, 32'h0000FFFF, 32'h0));
    vt.push_back(mk(16'h0008, 32'h0,  0, 0, 32'h0,        5, 0, 32'h0,        32'h0));  // 1 short of latency
    vt.push_back(mk(16'h0008, 32'h0,  0, 0, 32'h0,        1, 0, 32'h8,        32'h0));  // accepted at 6
    vt.push_back(mk(16'h0008, 32'h0,  0, 0, 32'h0,        1, 1, 32'h8,        32'h20)); // req 1 later
    vt.push_back(mk(16'h0028, 32'h0,  0, 0, 32'h0,        3, 0, 32'h8,        32'h20)); // 3-cycle glitch
    vt.push_back(mk(16'h0008, 32'h0,  0, 0, 32'h0,        6, 0, 32'h8,        32'h20));
    vt.push_back(mk(16'h0008, 32'h0,  0, 0, 32'h0,        1, 1, 32'h8,        32'h20));
    vt.push_back(mk(16'h0008, 32'h0,  1, 1, 32'h8,        1, 1, 32'h0,        32'h20)); // W1C
    vt.push_back(mk(16'h0008, 32'h20, 0, 0, 32'h0,        1, 1, 32'h0,        32'h0));  // ACK
    vt.push_back(mk(16'h0008, 32'h0,  0, 0, 32'h0,        1, 0, 32'h8,        32'h0));  // IDLE
    vt.push_back(mk(16'h0000, 32'h0,  0, 0, 32'h0,        6, 1, 32'h8,        32'h0));  // fall
    vt.push_back(mk(16'h0000, 32'h0,  0, 0, 32'h0,        1, 0, 32'h0,        32'h20));
    vt.push_back(mk(16'h0000, 32'h20, 0, 0, 32'h0,        1, 1, 32'h8,        32'h0));  // ACK, no W1C
    vt.push_back(mk(16'h0000, 32'h0,  0, 0, 32'h0,        1, 1, 32'h8,        32'h20)); // re-request
    vt.push_back(mk(16'h0000, 32'h0,  1, 1, 32'h8,        1, 1, 32'h0,        32'h20));
    vt.push_back(mk(16'h0000, 32'h10, 0, 0, 32'h0,        1, 1, 32'h0,        32'h20)); // wrong fin
    vt.push_back(mk(16'h0000, 32'h20, 0, 0, 32'h0,        1, 1, 32'h0,        32'h0));
    vt.push_back(mk(16'h0000, 32'h0,  0, 0, 32'h0,        1, 1, 32'h0,        32'h0));
    vt.push_back(mk(16'h0000, 32'h0,  1, 2, 32'hFFFF_FFF7, 1, 2, 32'h0000FFF7, 32'h0)); // mask
    vt.push_back(mk(16'h0008, 32'h0,  0, 0, 32'h0,        6, 1, 32'h8,        32'h0));
    vt.push_back(mk(16'h0008, 32'h0,  0, 0, 32'h0,        3, 1, 32'h8,        32'h0));  // masked
    vt.push_back(mk(16'h0008, 32'h0,  1, 2, 32'h0000FFFF, 1, 2, 32'h0000FFFF, 32'h0));
    vt.push_back(mk(16'h0008, 32'h0,  0, 0, 32'h0,        1, 1, 32'h8,        32'h20));
    vt.push_back(mk(16'h0008, 32'h0,  1, 1, 32'h8,        1, 1, 32'h0,        32'h20));
    vt.push_back(mk(16'h0008, 32'h20, 0, 0, 32'h0,        2, 0, 32'h8,        32'h0));
    vt.push_back(mk(16'h000C, 32'h0,  0, 0, 32'h0,        5, 1, 32'h0,        32'h0));
    vt.push_back(mk(16'h000C, 32'h0,  1, 1, 32'h4,        1, 1, 32'h4,        32'h0));  // set beats W1C
    vt.push_back(mk(16'h000C, 32'h0,  0, 0, 32'h0,        1, 0, 32'hC,        32'h20));

    for (int i = 0; i < vt.size(); i++) begin
      in_raw = vt[i].raw; int_fin_i = vt[i].fin; we = vt[i].wr;
      addr = {28'h0, vt[i].wreg, 2'b00}; wdata = vt[i].wdat;
      tick();
      we = 1'b0; int_fin_i = '0;
      repeat (vt[i].steps - 1) tick();
      rd(vt[i].rreg, $sformatf("vec%0d rdata", i), vt[i].exp_rd);
      check($sformatf("vec%0d int_req_o", i), int_req_o, vt[i].exp_req);
    end

    // Mask cleared while in REQ: request held until fin.
    wr(2'd2, 32'h0);
    repeat (3) tick();
    check("mask0 hold req", int_req_o, 32'h20);
    int_fin_i = 32'h20; tick(); int_fin_i = '0;
    check("mask0 fin ack", int_req_o, 32'h0);
    repeat (3) tick();
    check("mask0 idle", int_req_o, 32'h0);
    wr(2'd2, 32'hFFFF);
    tick();
    check("unmask req", int_req_o, 32'h20);

    // Reset mid-handshake, inputs still high: power-up report after release.
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst req", int_req_o, 32'h0);
    rd(2'd1, "rst pending", 32'h0);
    rd(2'd2, "rst mask", 32'h0000FFFF);
    repeat (5) tick();
    rd(2'd0, "pwrup state early", 32'h0);
    tick();
    rd(2'd0, "pwrup state", 32'hC);
    rd(2'd1, "pwrup pending", 32'hC);
    tick();
    check("pwrup req", int_req_o, 32'h20);
    wr(2'd1, 32'hFFFF);
    int_fin_i = 32'h20; tick(); int_fin_i = '0;
    tick();
    check("cleanup idle", int_req_o, 32'h0);

`ifdef IRQ_EDGE_SEL_EN
    wr(2'd2, 32'h0);
    wr(2'd3, 32'h1);
    rd(2'd3, "edge readback", 32'h1);
    in_raw = 16'h000D;
    repeat (6) tick();
    rd(2'd1, "edge rise pending", 32'h1);
    wr(2'd1, 32'h1);
    in_raw = 16'h000C;
    repeat (6) tick();
    rd(2'd0, "edge fall state", 32'hC);
    rd(2'd1, "edge fall no pending", 32'h0);
`else
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, "edge reg absent", 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
